sync_prescaled_counter: RTL and testbench
=========================================

SYNC_PRESCALED_COUNTER -- requirements
Module: sync_prescaled_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, total counter width in bits (legal range 8..32).
REQ-002 SHALL have parameter PRE_BITS, default 4, width of the low prescaler segment (legal range 1..WIDTH-1).
REQ-003 SHALL have the port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have the port CLR, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have the port EN, input, 1 bit: count enable.
REQ-006 SHALL have the port UP, input, 1 bit: direction (1 = up, 0 = down).
REQ-007 SHALL have the port LOAD, input, 1 bit: synchronous parallel load strobe.
REQ-008 SHALL have the port LOAD_VAL, input, WIDTH bits: value written into Q on LOAD.
REQ-009 SHALL have the port MAX, input, WIDTH bits: programmable terminal value (modulus minus 1).
REQ-010 SHALL have the port Q, output, WIDTH bits: counter value, driven directly from registers.
REQ-011 SHALL have the port TC, output, 1 bit: registered terminal-count pulse.
REQ-012 SHALL have the port PC, output, 1 bit: registered prescaler-carry pulse.

Function
REQ-013 SHALL give inputs the priority CLR > LOAD > EN; with none of them asserted, Q, TC and PC SHALL hold their values, except that TC and PC SHALL clear.
REQ-014 SHALL be fully synchronous: no derived or ripple clocks, with every flop clocked by CLK.
REQ-015 SHALL split Q into a prescaler segment Q[PRE_BITS-1:0] and a main segment Q[WIDTH-1:PRE_BITS]; the main segment SHALL step only on the edge where the prescaler wraps.
REQ-016 SHALL, in up mode with EN=1: if Q >= MAX, set Q to 0 on the next edge; otherwise set Q to Q+1.
REQ-017 SHALL, in down mode with EN=1: if Q == 0, set Q to MAX on the next edge; otherwise set Q to Q-1.
REQ-018 SHALL make Q track a pure binary count modulo MAX+1; segment borrows and carries SHALL be internal and never show a glitch on Q.
REQ-019 SHALL set TC=1 for exactly one cycle after each counting edge that performs a wrap (the edge that writes 0 in up mode, or MAX in down mode).
REQ-020 SHALL set PC=1 for exactly one cycle after each counting edge on which the prescaler segment wraps, including modulus wraps.
REQ-021 SHALL, on LOAD=1, set Q to LOAD_VAL and clear TC and PC on the next edge, regardless of EN; a LOAD_VAL above MAX SHALL be accepted, and the next up count SHALL then wrap to 0 with a TC pulse.
REQ-022 SHALL sample MAX every cycle; if MAX is lowered below the current Q, the next up count SHALL wrap to 0.
REQ-023 SHALL treat MAX=0 as a constant-zero counter that asserts TC after every counting edge.
REQ-024 SHALL apply a change on UP on the next counting edge, with no extra state.
REQ-025 SHALL have a combinational path to any output of zero length; every output SHALL be a flop output.

Reset
REQ-026 SHALL, on CLR=1 at a rising edge, set Q=0, TC=0 and PC=0, overriding LOAD and EN.
REQ-027 SHALL, when CLR is asserted in the middle of a count, discard any pending carry, and the first count after release SHALL start from 0.

Structure
REQ-028 SHALL place the default WIDTH and PRE_BITS constants and a direction enum (DIR_DOWN, DIR_UP) in the shared package counter_pkg.
REQ-029 SHALL instantiate sub-module count_segment twice (prescaler and main segment); each instance SHALL have a parameterised width, count enable, direction, load, a wrap-detect output and a carry-in.

Verification
REQ-030 SHALL verify, with defaults, MAX=16'hFFFF, EN=1, UP=1, from CLR, that 16 edges give Q=16'h0010, that PC is pulsed once after the 16th edge and TC stays 0.
REQ-031 SHALL verify, with MAX=16'd99, UP=1, counting from 0, that after 100 edges Q=0 with a one-cycle TC pulse, and that Q never exceeds 99.
REQ-032 SHALL verify, with UP=0, LOAD_VAL=16'd2, MAX=16'd99 and LOAD followed by 3 counting edges, the sequence Q=1, 0, 99 with TC high only after the third edge.
REQ-033 SHALL verify that LOAD_VAL=16'd200, MAX=16'd99, LOAD followed by one up edge gives Q=0 and TC=1.
REQ-034 SHALL verify that CLR, LOAD and EN asserted together at Q=16'h1234 give Q=0, TC=0 and PC=0 on the next edge.
REQ-035 SHALL verify that MAX lowered from 16'd500 to 16'd10 while Q=16'd300 causes the next up edge to give Q=0 with TC=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and direction type for the prescaled counter and its segments.
package counter_pkg;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_PRE_BITS = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;
endpackage

// File: rtl/count_segment.sv
// One slice of the counter: steps when enabled and its carry-in is set, flags
// when the step it is about to take rolls the slice over.
module count_segment
    import counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         carryIn,
    input  dir_e         dir,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic [W-1:0] q,
    output logic         wrap
);
    assign wrap = carryIn && ((dir == DIR_UP) ? (&q) : (q == '0));

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (load)
            q <= loadVal;
        else if (en && carryIn)
            q <= (dir == DIR_UP) ? q + 1'b1 : q - 1'b1;
    end
endmodule

// File: rtl/sync_prescaled_counter.sv
// Up/down modulo-(MAX+1) counter built from a prescaler segment and a main
// segment on one clock, with registered terminal-count and prescaler-carry pulses.
module sync_prescaled_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRE_BITS = DEF_PRE_BITS
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic [WIDTH-1:0] MAX,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             PC
);
    localparam int MAIN_BITS = WIDTH - PRE_BITS;

    dir_e                 dir;
    logic                 preWrap;
    logic                 mainWrap;
    logic                 modWrap;
    logic                 segLoad;
    logic [WIDTH-1:0]     segLoadVal;
    logic [PRE_BITS-1:0]  preQ;
    logic [MAIN_BITS-1:0] mainQ;

    assign dir = UP ? DIR_UP : DIR_DOWN;

    // Main wrap means Q is all ones (up) or exactly zero (down); the up case is
    // already covered by Q >= MAX, the down case is the whole modulus test.
    assign modWrap    = (dir == DIR_UP) ? ((Q >= MAX) || mainWrap) : mainWrap;
    assign segLoad    = LOAD || (EN && modWrap);
    assign segLoadVal = LOAD ? LOAD_VAL : ((dir == DIR_UP) ? '0 : MAX);

    count_segment #(.W(PRE_BITS)) uPre (
        .clk     (CLK),
        .clr     (CLR),
        .en      (EN),
        .carryIn (1'b1),
        .dir     (dir),
        .load    (segLoad),
        .loadVal (segLoadVal[PRE_BITS-1:0]),
        .q       (preQ),
        .wrap    (preWrap)
    );

    count_segment #(.W(MAIN_BITS)) uMain (
        .clk     (CLK),
        .clr     (CLR),
        .en      (EN),
        .carryIn (preWrap),
        .dir     (dir),
        .load    (segLoad),
        .loadVal (segLoadVal[WIDTH-1:PRE_BITS]),
        .q       (mainQ),
        .wrap    (mainWrap)
    );

    assign Q = {mainQ, preQ};

    always_ff @(posedge CLK) begin
        if (CLR || LOAD || !EN) begin
            TC <= 1'b0;
            PC <= 1'b0;
        end else begin
            TC <= modWrap;
            PC <= modWrap || preWrap;
        end
    end
endmodule

// File: tb/tb_sync_prescaled_counter.sv
// Directed bench for sync_prescaled_counter: a per-cycle arithmetic model plus
// hand-computed expectations for the key scenarios.
module tb_sync_prescaled_counter;
    localparam int WIDTH    = 16;
    localparam int PRE_BITS = 4;

    logic             CLK = 1'b0;
    logic             CLR = 1'b1;
    logic             EN = 1'b0;
    logic             UP = 1'b1;
    logic             LOAD = 1'b0;
    logic [WIDTH-1:0] LOAD_VAL = '0;
    logic [WIDTH-1:0] MAX = '1;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             PC;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;

    logic [WIDTH-1:0] mq = '0;
    logic             mtc = 1'b0;
    logic             mpc = 1'b0;

    sync_prescaled_counter #(.WIDTH(WIDTH), .PRE_BITS(PRE_BITS)) dut (
        .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .MAX(MAX), .Q(Q), .TC(TC), .PC(PC)
    );

    always #5 CLK = ~CLK;

    // Reference: plain modular arithmetic on the whole value.
    always @(posedge CLK) begin
        if (CLR) begin
            mq = '0; mtc = 0; mpc = 0;
        end else if (LOAD) begin
            mq = LOAD_VAL; mtc = 0; mpc = 0;
        end else if (EN) begin
            if (UP) begin
                if (mq >= MAX) begin
                    mq = '0; mtc = 1; mpc = 1;
                end else begin
                    mq = mq + 1; mtc = 0;
                    mpc = (mq % (1 << PRE_BITS)) == 0;
                end
            end else begin
                if (mq == 0) begin
                    mq = MAX; mtc = 1; mpc = 1;
                end else begin
                    mpc = (mq % (1 << PRE_BITS)) == 0;
                    mq = mq - 1; mtc = 0;
                end
            end
        end else begin
            mtc = 0; mpc = 0;
        end
    end

    always @(negedge CLK) begin
        if (checkOn) begin
            checks++;
            if (Q !== mq || TC !== mtc || PC !== mpc) begin
                errors++;
                $display("FAIL model t=%0t Q/TC/PC got %h/%b/%b want %h/%b/%b",
                         $time, Q, TC, PC, mq, mtc, mpc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    int pcCnt, tcCnt, maxQ;

    initial begin
        @(negedge CLK);
        CLR = 1; tick();
        checkOn = 1;
        chk("reset Q", Q, 0);
        chk("reset TC", TC, 0);
        chk("reset PC", PC, 0);

        // 16 up edges, full-range modulus
        CLR = 0; MAX = 16'hFFFF; EN = 1; UP = 1;
        pcCnt = 0; tcCnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            pcCnt += PC; tcCnt += TC;
        end
        chk("prescale Q", Q, 16'h0010);
        chk("prescale PC now", PC, 1);
        chk("prescale PC count", pcCnt, 1);
        chk("prescale TC count", tcCnt, 0);

        // modulus 100 from 0
        CLR = 1; tick(); CLR = 0; MAX = 16'd99;
        pcCnt = 0; tcCnt = 0; maxQ = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            tcCnt += TC;
            if (Q > maxQ) maxQ = Q;
        end
        chk("mod100 Q", Q, 0);
        chk("mod100 TC", TC, 1);
        chk("mod100 TC count", tcCnt, 1);
        chk("mod100 max Q", maxQ, 99);
        tick();
        chk("mod100 TC one-shot", TC, 0);

        // down count from a load of 2
        UP = 0; LOAD = 1; LOAD_VAL = 16'd2; tick(); LOAD = 0;
        chk("down load Q", Q, 2);
        tick(); chk("down1 Q", Q, 1); chk("down1 TC", TC, 0);
        tick(); chk("down2 Q", Q, 0); chk("down2 TC", TC, 0);
        tick(); chk("down3 Q", Q, 99); chk("down3 TC", TC, 1);

        // load above MAX, then up
        UP = 1; LOAD = 1; LOAD_VAL = 16'd200; tick(); LOAD = 0;
        chk("overload Q", Q, 200);
        chk("overload TC", TC, 0);
        tick();
        chk("overload wrap Q", Q, 0);
        chk("overload wrap TC", TC, 1);

        // CLR beats LOAD and EN
        MAX = 16'hFFFF; LOAD = 1; LOAD_VAL = 16'h1234; tick();
        chk("pre-clr Q", Q, 16'h1234);
        CLR = 1; LOAD = 1; LOAD_VAL = 16'h5555; EN = 1; tick();
        CLR = 0; LOAD = 0;
        chk("clr prio Q", Q, 0);
        chk("clr prio TC", TC, 0);
        chk("clr prio PC", PC, 0);
        tick();
        chk("after clr Q", Q, 1);

        // MAX lowered under current value
        MAX = 16'd500; LOAD = 1; LOAD_VAL = 16'd300; tick(); LOAD = 0;
        MAX = 16'd10; tick();
        chk("max lowered Q", Q, 0);
        chk("max lowered TC", TC, 1);

        // hold: no inputs asserted
        tick(); tick(); EN = 0;
        tick();
        chk("hold Q", Q, 2);
        chk("hold TC", TC, 0);

        // MAX = 0 in both directions
        MAX = 0; EN = 1; UP = 1; CLR = 1; tick(); CLR = 0;
        tick(); chk("max0 up Q", Q, 0); chk("max0 up TC", TC, 1);
        tick(); chk("max0 up TC again", TC, 1);
        UP = 0;
        tick(); chk("max0 down Q", Q, 0); chk("max0 down TC", TC, 1);

        // down through a prescaler borrow
        MAX = 16'hFFFF; LOAD = 1; LOAD_VAL = 16'h0020; tick(); LOAD = 0;
        tick(); chk("borrow Q", Q, 16'h001F); chk("borrow PC", PC, 1);
        tick(); chk("borrow PC clear", PC, 0);

        // mixed traffic against the model
        for (int i = 0; i < 600; i++) begin
            CLR  = ($urandom_range(0, 60) == 0);
            LOAD = ($urandom_range(0, 25) == 0);
            EN   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 30) == 0) UP = ~UP;
            if ($urandom_range(0, 80) == 0)
                MAX = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 40));
            LOAD_VAL = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 50));
            tick();
        end

        checkOn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
